// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback with mem_ready stalls.
// Define MC_CONTROL_TRAP_EN to make illegal opcodes trap until reset instead of executing as a NOP.
module mc_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       trap
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXEC   = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXEC   = 4'd10,
    S_IWB     = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  state_t state_q, state_d;
  // lw/sw choice is captured in DECODE because opcode is not trusted in MEMADR.
  logic   is_lw_q, is_lw_d;

  // State register with synchronous reset into FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_lw_q <= is_lw_d;
    end
  end

  // Next-state and Moore outputs; reset forces every output low.
  always_comb begin
    state_d       = state_q;
    is_lw_d       = is_lw_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_zero      = 1'b0;
    alu_op        = 3'b000;
    instr_done    = 1'b0;
    trap          = 1'b0;
    if (reset) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready) state_d = S_DECODE;
          else           state_d = S_FETCH;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          is_lw_d   = (opcode == OP_LW);
          case (opcode)
            OP_LW, OP_SW:               state_d = S_MEMADR;
            OP_R:                       state_d = S_REXEC;
            OP_BEQ:                     state_d = S_BRANCH;
            OP_J:                       state_d = S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI:   state_d = S_IEXEC;
            default:                    state_d = S_ILLEGAL;
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = is_lw_q ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
          else           state_d = S_MEMRD;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          i_or_d     = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
          if (mem_ready) state_d = S_FETCH;
          else           state_d = S_MEMWR;
        end
        S_REXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b111;
          state_d   = S_RWB;
        end
        S_RWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 3'b001;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_done    = 1'b1;
          state_d       = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_IEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          case (opcode)
            OP_ANDI: begin alu_op = 3'b010; ext_zero = 1'b1; end
            OP_ORI:  begin alu_op = 3'b011; ext_zero = 1'b1; end
            default: begin alu_op = 3'b000; ext_zero = 1'b0; end
          endcase
          state_d = S_IWB;
        end
        S_IWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_ILLEGAL: begin
`ifdef MC_CONTROL_TRAP_EN
          trap    = 1'b1;
          state_d = S_ILLEGAL;
`else
          instr_done = 1'b1;
          state_d    = S_FETCH;
`endif
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: each instruction is expanded into its expected per-cycle
// timeline (with stalls), compared every cycle, then key cycles are pinned with literal values.
module tb_mc_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       trap;
  } outs_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J = 6'b000010, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam int K_FETCH = 0, K_DEC = 1, K_ADR = 2, K_RD = 3, K_MWB = 4, K_WR = 5, K_RX = 6;
  localparam int K_RWB = 7, K_BR = 8, K_J = 9, K_IX = 10, K_IWB = 11, K_ILL = 12;

  logic clk, reset, mem_ready;
  logic [5:0] opcode;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic reg_write, alu_src_a, ext_zero, instr_done, trap;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] alu_op;
  outs_t dut_o;

  mc_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .alu_op(alu_op), .instr_done(instr_done), .trap(trap)
  );

  assign dut_o = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_zero, alu_op, instr_done, trap};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit         v_rst[$];
  bit         v_mr[$];
  logic [5:0] v_op[$];
  outs_t      v_exp[$];
  outs_t      act_q[$];
  int         budget = -1;
  bit         ign_mr = 1'b1;
  int         last_start;
  int         checks = 0;
  int         errors = 0;

  function automatic outs_t expect_step(int kind, bit mr, logic [5:0] op);
    outs_t o = '0;
    case (kind)
      K_FETCH: begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
      K_DEC:   o.alu_src_b = 2'b11;
      K_ADR:   begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      K_RD:    begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
      K_MWB:   begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1; end
      K_WR:    begin o.i_or_d = 1'b1; o.mem_write = 1'b1; o.instr_done = mr; end
      K_RX:    begin o.alu_src_a = 1'b1; o.alu_op = 3'b111; end
      K_RWB:   begin o.reg_write = 1'b1; o.reg_dst = 1'b1; o.instr_done = 1'b1; end
      K_BR:    begin o.alu_src_a = 1'b1; o.alu_op = 3'b001; o.pc_write_cond = 1'b1;
                     o.pc_source = 2'b01; o.instr_done = 1'b1; end
      K_J:     begin o.pc_write = 1'b1; o.pc_source = 2'b10; o.instr_done = 1'b1; end
      K_IX:    begin
                 o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                 o.alu_op   = (op == OP_ANDI) ? 3'b010 : (op == OP_ORI) ? 3'b011 : 3'b000;
                 o.ext_zero = (op == OP_ANDI) || (op == OP_ORI);
               end
      K_IWB:   begin o.reg_write = 1'b1; o.instr_done = 1'b1; end
`ifdef MC_CONTROL_TRAP_EN
      K_ILL:   o.trap = 1'b1;
`else
      K_ILL:   o.instr_done = 1'b1;
`endif
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic push(bit rst, bit mr, logic [5:0] op, outs_t e);
    if (budget != 0) begin
      v_rst.push_back(rst); v_mr.push_back(mr); v_op.push_back(op); v_exp.push_back(e);
      if (budget > 0) budget--;
    end
  endtask

  task automatic push_reset();
    push(1'b1, 1'b1, 6'b101010, '0);
  endtask

  // Expand one instruction into its cycle timeline; opcode is valid only in decode/immediate-execute,
  // elsewhere a misleading value is driven, and mem_ready toggles in states that must ignore it.
  task automatic add_instr(logic [5:0] op, int fs, int ms);
    logic [5:0] junk = op ^ 6'b001000;
    bit ig = ign_mr;
    ign_mr = ~ign_mr;
    last_start = v_exp.size();
    for (int k = 0; k < fs; k++) push(1'b0, 1'b0, junk, expect_step(K_FETCH, 1'b0, op));
    push(1'b0, 1'b1, junk, expect_step(K_FETCH, 1'b1, op));
    push(1'b0, ig, op, expect_step(K_DEC, ig, op));
    case (op)
      OP_LW: begin
        push(1'b0, ig, junk, expect_step(K_ADR, ig, op));
        for (int k = 0; k < ms; k++) push(1'b0, 1'b0, junk, expect_step(K_RD, 1'b0, op));
        push(1'b0, 1'b1, junk, expect_step(K_RD, 1'b1, op));
        push(1'b0, ig, junk, expect_step(K_MWB, ig, op));
      end
      OP_SW: begin
        push(1'b0, ig, junk, expect_step(K_ADR, ig, op));
        for (int k = 0; k < ms; k++) push(1'b0, 1'b0, junk, expect_step(K_WR, 1'b0, op));
        push(1'b0, 1'b1, junk, expect_step(K_WR, 1'b1, op));
      end
      OP_R: begin
        push(1'b0, ig, junk, expect_step(K_RX, ig, op));
        push(1'b0, ig, junk, expect_step(K_RWB, ig, op));
      end
      OP_BEQ: push(1'b0, ig, junk, expect_step(K_BR, ig, op));
      OP_J:   push(1'b0, ig, junk, expect_step(K_J, ig, op));
      OP_ADDI, OP_ANDI, OP_ORI: begin
        push(1'b0, ig, op, expect_step(K_IX, ig, op));
        push(1'b0, ig, junk, expect_step(K_IWB, ig, op));
      end
      default: begin
`ifdef MC_CONTROL_TRAP_EN
        for (int k = 0; k < 10; k++) push(1'b0, k[0], junk, expect_step(K_ILL, k[0], op));
        push_reset();
`else
        push(1'b0, ig, junk, expect_step(K_ILL, ig, op));
`endif
      end
    endcase
  endtask

  task automatic chk(string name, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  int s_andi, s_lw, s_seq, s_abn, s_ill, n;

  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = 6'b000000;
    push_reset(); push_reset();
    add_instr(OP_ANDI, 0, 0); s_andi = last_start;
    add_instr(OP_LW, 2, 3);   s_lw = last_start;
    add_instr(OP_R, 0, 0);    s_seq = last_start;
    add_instr(OP_SW, 0, 0);
    add_instr(OP_BEQ, 0, 0);
    add_instr(OP_J, 0, 0);
    add_instr(OP_ADDI, 1, 0);
    add_instr(OP_ORI, 0, 0);
    add_instr(OP_LW, 0, 0);
    add_instr(OP_SW, 1, 2);
    budget = 2; add_instr(OP_R, 0, 0); s_abn = last_start; budget = -1;
    push_reset();
    add_instr(OP_BAD, 0, 0);  s_ill = last_start;
    add_instr(OP_ADDI, 0, 0);

    @(posedge clk); #1;
    for (int i = 0; i < v_exp.size(); i++) begin
      reset = v_rst[i]; mem_ready = v_mr[i]; opcode = v_op[i];
      @(negedge clk);
      act_q.push_back(dut_o);
      checks++;
      if (dut_o !== v_exp[i]) begin
        errors++;
        $display("FAIL step %0d: got %h expected %h", i, dut_o, v_exp[i]);
      end
      @(posedge clk); #1;
    end

    chk("reset_outputs_zero", int'(act_q[1]), 0);
    chk("fetch_after_reset_mem_read", int'(act_q[s_andi].mem_read), 1);
    chk("fetch_after_reset_alu_src_b", int'(act_q[s_andi].alu_src_b), 1);
    chk("andi_c1_ir_pc_write", int'({act_q[s_andi].ir_write, act_q[s_andi].pc_write}), 3);
    chk("andi_c3_alu_op", int'(act_q[s_andi + 2].alu_op), 2);
    chk("andi_c3_ext_zero", int'(act_q[s_andi + 2].ext_zero), 1);
    chk("andi_c4_wb", int'({act_q[s_andi + 3].reg_write, act_q[s_andi + 3].reg_dst,
                            act_q[s_andi + 3].instr_done}), 5);
    chk("lw_done_c10", int'(act_q[s_lw + 9].instr_done), 1);
    n = 0;
    for (int i = s_lw; i <= s_lw + 9; i++) n += int'(act_q[i].reg_write & act_q[i].mem_to_reg);
    chk("lw_mdr_write_once", n, 1);
    chk("seq_done_pattern", int'({act_q[s_seq + 3].instr_done, act_q[s_seq + 7].instr_done,
                                  act_q[s_seq + 10].instr_done, act_q[s_seq + 13].instr_done}), 15);
    n = 0;
    for (int i = s_seq; i <= s_seq + 13; i++) n += int'(act_q[i].instr_done);
    chk("seq_done_count", n, 4);
    chk("seq_mem_write_c8", int'(act_q[s_seq + 7].mem_write), 1);
    n = 0;
    for (int i = s_seq; i <= s_seq + 13; i++) n += int'(act_q[i].mem_write);
    chk("seq_mem_write_count", n, 1);
    n = 0;
    for (int i = s_abn; i <= s_abn + 2; i++) n += int'(act_q[i].reg_write);
    chk("abandon_no_reg_write", n, 0);
    chk("abandon_fetch_next", int'(act_q[s_abn + 3].mem_read), 1);
`ifdef MC_CONTROL_TRAP_EN
    n = 0;
    for (int i = s_ill + 2; i <= s_ill + 11; i++) n += int'(act_q[i].trap);
    chk("illegal_trap_persist", n, 10);
    n = 0;
    for (int i = s_ill + 2; i <= s_ill + 11; i++)
      n += int'(act_q[i].reg_write | act_q[i].mem_write | act_q[i].ir_write | act_q[i].pc_write);
    chk("illegal_no_writes", n, 0);
    chk("illegal_fetch_after_reset", int'(act_q[s_ill + 13].mem_read), 1);
`else
    chk("illegal_done_c3", int'(act_q[s_ill + 2].instr_done), 1);
    chk("illegal_trap_low", int'(act_q[s_ill + 2].trap), 0);
    chk("illegal_fetch_c4", int'(act_q[s_ill + 3].mem_read), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
